// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch stage that drives the imem SRAM read port and buffers returned words for decode
module imem_fetch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH+1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH+1:0] redirect_pc,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH+1:0] inst_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc_q, req_pc_q;
    logic                  inflight_q;
    logic [CW-1:0]         count_q, credit;
    logic [PW-1:0]         rd_q, wr_q;
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem [FIFO_DEPTH];
    logic                  empty, pop, issue, unused;

    assign empty      = count_q == '0;
    assign inst_valid = !empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    // credit is also next-cycle occupancy: every in-flight read lands in the FIFO next edge
    assign credit     = count_q + CW'(inflight_q) - CW'(pop);
    assign issue      = rst_n && fetch_en && !redirect_valid && credit < CW'(FIFO_DEPTH);
    assign csb0       = !issue;
    assign web0       = 1'b1;
    assign addr0      = pc_q;
    assign din0       = '0;
    assign inst_data  = empty ? '0 : data_mem[rd_q];
    assign inst_pc    = empty ? '0 : {pc_mem[rd_q], 2'b00};
    assign unused     = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC[ADDR_WIDTH+1:2];
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc[ADDR_WIDTH+1:2];
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            pc_q       <= issue ? pc_q + 1'b1 : pc_q;
            req_pc_q   <= issue ? pc_q : req_pc_q;
            inflight_q <= issue;
            wr_q       <= wr_q + PW'(inflight_q);
            rd_q       <= rd_q + PW'(pop);
            count_q    <= credit;
        end
    end

    // dout0 is only sampled on the edge that closes an in-flight read, so X never enters the buffer
    always_ff @(posedge clk) begin
        if (inflight_q && !redirect_valid) begin
            data_mem[wr_q] <= dout0;
            pc_mem[wr_q]   <= req_pc_q;
        end
    end
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: randomized and directed bench for imem_fetch with an SRAM model and an in-order expected-stream scoreboard
module tb_imem_fetch;
    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect_valid, inst_ready;
    logic [9:0]  redirect_pc;
    logic        csb0, web0, inst_valid;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0, inst_data;
    logic [9:0]  inst_pc;

    logic [31:0] mem [256];
    logic [41:0] exp_q [$];
    logic [41:0] sb_e;
    logic [9:0]  push_pc;
    int          tests = 0, fails = 0, pops = 0;

    imem_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(10'h010), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // SRAM: data appears one clock after the request edge and is not held
    always @(posedge clk) dout0 <= !csb0 ? mem[addr0] : 'x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // the delivered stream after any reset/redirect is consecutive word PCs from the target
    function automatic void refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back({push_pc, mem[push_pc[9:2]]});
            push_pc = push_pc + 10'd4;
        end
    endfunction

    function automatic void restart(input logic [9:0] p);
        exp_q.delete();
        push_pc = {p[9:2], 2'b00};
        refill();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        refill();
    endtask

    task automatic do_redirect(input logic [9:0] p);
        redirect_valid = 1'b1;
        redirect_pc    = p;
        restart(p);
    endtask

    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got pc %h with nothing expected", inst_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_pc", 32'(inst_pc), 32'(sb_e[41:32]));
                chk("sb_data", inst_data, sb_e[31:0]);
            end
        end
    end

    initial begin
        int p0, bad;
        bit found;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        restart(10'h010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_csb0", 32'(csb0), 1);
        chk("rst_web0", 32'(web0), 1);
        chk("rst_addr0", 32'(addr0), 4);
        chk("rst_din0", din0, 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", 32'(inst_pc), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_addr0", 32'(addr0), 32'(4 + k));
            chk("t1_csb0", 32'(csb0), 0);
            if (k >= 2) begin
                chk("t1_valid", 32'(inst_valid), 1);
                chk("t1_pc", 32'(inst_pc), 32'(16 + 4 * (k - 2)));
            end
            step();
        end
        // back-pressure: buffer fills to depth then stops requesting
        inst_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("t2_valid", 32'(inst_valid), 1);
        chk("t2_csb0", 32'(csb0), 1);
        step();
        fetch_en = 1'b0; inst_ready = 1'b1;
        p0 = pops;
        repeat (8) step();
        chk("t2_buffered", 32'(pops - p0), 4);
        // redirect while full-ish with a read in flight
        fetch_en = 1'b1; inst_ready = 1'b0;
        repeat (8) step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        do_redirect(10'h200);
        @(negedge clk);
        chk("t3_valid_r", 32'(inst_valid), 0);
        chk("t3_csb0_r", 32'(csb0), 1);
        step();
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t3_csb0_r1", 32'(csb0), 0);
        chk("t3_addr0_r1", 32'(addr0), 32'h80);
        chk("t3_empty_r1", 32'(inst_valid), 0);
        step();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                found = 1'b1;
                chk("t3_first_pc", 32'(inst_pc), 32'h200);
                chk("t3_first_data", inst_data, mem[8'h80]);
            end
            step();
        end
        if (!found) begin
            tests++; fails++;
            $display("FAIL t3_timeout: no instruction within 10 cycles after redirect");
        end
        // PC wrap
        do_redirect(10'h3F8);
        step();
        @(negedge clk); chk("t4_addr_fe", 32'(addr0), 32'hFE); step();
        @(negedge clk); chk("t4_addr_ff", 32'(addr0), 32'hFF); step();
        @(negedge clk); chk("t4_addr_00", 32'(addr0), 32'h00); step();
        repeat (6) step();
        // single issue then fetch_en low
        fetch_en = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("t5_drained", 32'(inst_valid), 0);
        step();
        fetch_en = 1'b1;
        @(negedge clk);
        chk("t5_issue", 32'(csb0), 0);
        p0 = pops;
        step();
        fetch_en = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (!csb0) bad++;
            step();
        end
        chk("t5_no_issue", 32'(bad), 0);
        chk("t5_one_word", 32'(pops - p0), 1);
        // back-to-back redirects: last one wins
        fetch_en = 1'b1;
        do_redirect(10'h100);
        step();
        do_redirect(10'h204);
        step();
        repeat (8) step();
        // async reset mid-stream
        repeat (20) begin
            inst_ready = ($urandom % 2) == 0;
            step();
        end
        #2;
        rst_n = 1'b0;
        restart(10'h010);
        #1;
        chk("t6_csb0", 32'(csb0), 1);
        chk("t6_valid", 32'(inst_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t6_addr0", 32'(addr0), 4);
        chk("t6_csb0_run", 32'(csb0), 0);
        step();
        repeat (6) step();
        // randomized traffic
        repeat (400) begin
            fetch_en   = ($urandom % 8) != 0;
            inst_ready = ($urandom % 4) != 0;
            if (($urandom % 16) == 0) do_redirect(10'($urandom));
            step();
        end
        fetch_en = 1'b0; inst_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("final_drained", 32'(inst_valid), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
